// File: rtl/conv_accumulator.sv
// Window accumulator behind the product multiplier. It sums TAPS consecutive products and presents
// each window sum on a valid/ready port. Define ACC_SAT_EN to get saturating instead of wrapping sums.
module conv_accumulator #(
  parameter int unsigned PROD_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 24,
  parameter int unsigned TAPS       = 9,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  sclr_n,
  input  logic                  clken,
  input  logic                  in_valid,
  input  logic [PROD_WIDTH-1:0] in_product,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_sum,
  output logic [CNT_WIDTH-1:0]  win_count,
  output logic                  overrun,
  output logic                  busy
);

  localparam int unsigned TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);

  typedef enum logic {
    ACC_IDLE,
    ACC_RUN
  } state_e;

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [TAP_W-1:0]       cnt_q, cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0]   out_sum_q, out_sum_d;
  logic [CNT_WIDTH-1:0]   win_count_q, win_count_d;
  logic                   overrun_q, overrun_d;

  logic                   accept;
  logic                   complete;
  logic [ACC_WIDTH-1:0]   acc_base;
  logic [ACC_WIDTH-1:0]   prod_ext;
  logic [ACC_WIDTH-1:0]   sum_w;

  // A window opens from zero, so the idle state adds the product to nothing.
  assign accept   = clken && in_valid;
  assign acc_base = (state_q == ACC_RUN) ? acc_q : '0;
  assign prod_ext = ACC_WIDTH'(in_product);

`ifdef ACC_SAT_EN
  logic [ACC_WIDTH:0] sum_wide;
  assign sum_wide = {1'b0, acc_base} + {1'b0, prod_ext};
  assign sum_w    = sum_wide[ACC_WIDTH] ? '1 : sum_wide[ACC_WIDTH-1:0];
`else
  assign sum_w    = acc_base + prod_ext;
`endif

  always_comb begin
    complete = 1'b0;
    if (accept) begin
      if (TAPS == 1) complete = 1'b1;
      else           complete = (state_q == ACC_RUN) && (cnt_q == LAST_TAP);
    end
  end

  // NOTE: every next-state value gets its default first, so partial branches never infer a latch.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    win_count_d = win_count_q;
    overrun_d   = overrun_q;

    if (accept) begin
      acc_d = sum_w;
      if (complete) begin
        state_d = ACC_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = ACC_RUN;
        cnt_d   = cnt_q + 1'b1;
      end
    end

    // A completion always wins over a consume; only an unconsumed result is lost.
    if (complete) begin
      out_valid_d = 1'b1;
      out_sum_d   = sum_w;
      win_count_d = win_count_q + 1'b1;
      if (out_valid_q && !out_ready) overrun_d = 1'b1;
    end else if (clken && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the reset is synchronous and overrides clken.
  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      state_q     <= ACC_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      win_count_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      win_count_q <= win_count_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign win_count = win_count_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == ACC_RUN);

endmodule

// File: tb/tb_conv_accumulator.sv
// Bench for conv_accumulator: three instances (default, 16-bit accumulator, single tap) driven in
// parallel and compared against a window-sum model, plus directed corner-case sequences.
module tb_conv_accumulator;

  logic        clock = 1'b0;
  logic        sclr_n, clken, in_valid, out_ready;
  logic [15:0] in_product;

  always #5 clock = ~clock;

  logic        v0, v1, v2, ov0, ov1, ov2, b0, b1, b2;
  logic [23:0] s0, s2;
  logic [15:0] s1;
  logic [15:0] wc0, wc1, wc2;

  conv_accumulator dut (
    .clock(clock), .sclr_n(sclr_n), .clken(clken), .in_valid(in_valid), .in_product(in_product),
    .out_valid(v0), .out_ready(out_ready), .out_sum(s0), .win_count(wc0), .overrun(ov0), .busy(b0));

  conv_accumulator #(.ACC_WIDTH(16)) dut_w16 (
    .clock(clock), .sclr_n(sclr_n), .clken(clken), .in_valid(in_valid), .in_product(in_product),
    .out_valid(v1), .out_ready(out_ready), .out_sum(s1), .win_count(wc1), .overrun(ov1), .busy(b1));

  conv_accumulator #(.TAPS(1)) dut_t1 (
    .clock(clock), .sclr_n(sclr_n), .clken(clken), .in_valid(in_valid), .in_product(in_product),
    .out_valid(v2), .out_ready(out_ready), .out_sum(s2), .win_count(wc2), .overrun(ov2), .busy(b2));

  logic        dv[3];
  logic        dov[3];
  logic        db[3];
  logic [23:0] ds[3];
  logic [15:0] dwc[3];
  assign dv[0] = v0;  assign dv[1] = v1;  assign dv[2] = v2;
  assign dov[0] = ov0; assign dov[1] = ov1; assign dov[2] = ov2;
  assign db[0] = b0;  assign db[1] = b1;  assign db[2] = b2;
  assign ds[0] = s0;  assign ds[1] = {8'd0, s1}; assign ds[2] = s2;
  assign dwc[0] = wc0; assign dwc[1] = wc1; assign dwc[2] = wc2;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a window is a running mathematical total of its products; the result is
  // that total reduced to the accumulator width by wrap or clamp.
  int unsigned     m_taps[3]  = '{9, 9, 1};
  int unsigned     m_width[3] = '{24, 16, 24};
  longint unsigned m_total[3];
  int unsigned     m_cnt[3];
  logic            m_valid[3];
  longint unsigned m_sum[3];
  int unsigned     m_wc[3];
  logic            m_ovr[3];

  task automatic model_update(input logic ce, rn, iv, input logic [15:0] p, input logic rdy);
    for (int d = 0; d < 3; d++) begin
      longint unsigned maxv, res;
      bit done;
      maxv = (64'd1 << m_width[d]) - 1;
      done = 1'b0;
      res  = 0;
      if (!rn) begin
        m_total[d] = 0; m_cnt[d] = 0; m_valid[d] = 1'b0;
        m_sum[d] = 0; m_wc[d] = 0; m_ovr[d] = 1'b0;
      end else if (ce) begin
        if (iv) begin
          m_total[d] += p;
          m_cnt[d]++;
          if (m_cnt[d] == m_taps[d]) begin
`ifdef ACC_SAT_EN
            res = (m_total[d] > maxv) ? maxv : m_total[d];
`else
            res = m_total[d] & maxv;
`endif
            done = 1'b1;
            m_total[d] = 0;
            m_cnt[d] = 0;
          end
        end
        if (done) begin
          if (m_valid[d] && !rdy) m_ovr[d] = 1'b1;
          m_valid[d] = 1'b1;
          m_sum[d] = res;
          m_wc[d] = (m_wc[d] + 1) % 65536;
        end else if (rdy) begin
          m_valid[d] = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("model_valid[%0d]", d), dv[d], m_valid[d]);
      check($sformatf("model_sum[%0d]", d), ds[d], m_sum[d]);
      check($sformatf("model_wc[%0d]", d), dwc[d], m_wc[d]);
      check($sformatf("model_ovr[%0d]", d), dov[d], m_ovr[d]);
      check($sformatf("model_busy[%0d]", d), db[d], m_cnt[d] != 0);
    end
  endtask

  task automatic step(input logic ce, rn, iv, input logic [15:0] p, input logic rdy);
    clken = ce; sclr_n = rn; in_valid = iv; in_product = p; out_ready = rdy;
    @(posedge clock);
    #1;
    model_update(ce, rn, iv, p, rdy);
    compare_all();
  endtask

  typedef struct {
    logic        ce, rn, iv;
    logic [15:0] prod;
    logic        rdy;
    logic        e_valid;
    logic [23:0] e_sum;
    logic [15:0] e_wc;
    logic        e_busy;
  } vec_t;

  vec_t tbl[11];

  initial begin
    sclr_n = 1'b0; clken = 1'b0; in_valid = 1'b0; in_product = '0; out_ready = 1'b0;

    // Basic window: reset, nine back-to-back 50s, then one consume cycle.
    tbl[0] = '{ce: 1, rn: 0, iv: 0, prod: 0, rdy: 1, e_valid: 0, e_sum: 0, e_wc: 0, e_busy: 0};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{ce: 1, rn: 1, iv: 1, prod: 50, rdy: 1, e_valid: 0, e_sum: 0, e_wc: 0, e_busy: 1};
    tbl[9]  = '{ce: 1, rn: 1, iv: 1, prod: 50, rdy: 1, e_valid: 1, e_sum: 450, e_wc: 1, e_busy: 0};
    tbl[10] = '{ce: 1, rn: 1, iv: 0, prod: 0, rdy: 1, e_valid: 0, e_sum: 450, e_wc: 1, e_busy: 0};

    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    check("reset_valid", v0, 0);
    check("reset_sum", s0, 0);
    check("reset_wc", wc0, 0);
    check("reset_ovr", ov0, 0);
    check("reset_busy", b0, 0);

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].ce, tbl[i].rn, tbl[i].iv, tbl[i].prod, tbl[i].rdy);
      check($sformatf("tbl%0d_valid", i), v0, tbl[i].e_valid);
      check($sformatf("tbl%0d_sum", i), s0, tbl[i].e_sum);
      check($sformatf("tbl%0d_wc", i), wc0, tbl[i].e_wc);
      check($sformatf("tbl%0d_busy", i), b0, tbl[i].e_busy);
    end

    // Gaps and clken: alternate idle cycles, and three disabled cycles mid-window.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 1'b1, 16'd50, 1'b1);
      if (i < 8) check("gap_busy", b0, 1);
      if (i == 3) begin
        for (int k = 0; k < 3; k++) begin
          step(1'b0, 1'b1, 1'b1, 16'd999, 1'b1);
          check("clken_busy_hold", b0, 1);
          check("clken_wc_hold", wc0, 1);
        end
      end
      if (i < 8) step(1'b1, 1'b1, 1'b0, 16'd0, 1'b1);
    end
    check("gap_valid", v0, 1);
    check("gap_sum", s0, 450);
    check("gap_wc", wc0, 2);
    check("gap_busy_end", b0, 0);
    for (int k = 0; k < 2; k++) step(1'b0, 1'b1, 1'b0, 16'd0, 1'b1);
    check("clken_valid_hold", v0, 1);
    check("clken_sum_hold", s0, 450);

    // Wrap vs saturate on the 16-bit accumulator.
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1);
    check("w16_valid", v1, 1);
`ifdef ACC_SAT_EN
    check("w16_sum", s1, 65535);
`else
    check("w16_sum", s1, 65527);
`endif
    check("w24_sum", s0, 589815);

    // Back-pressure: two windows with no consume.
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b1, 16'd1, 1'b0);
    check("bp_first_valid", v0, 1);
    check("bp_first_ovr", ov0, 0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b1, 16'd2, 1'b0);
    check("bp_valid", v0, 1);
    check("bp_sum", s0, 18);
    check("bp_ovr", ov0, 1);
    check("bp_wc", wc0, 2);
    step(1'b1, 1'b1, 1'b0, 16'd0, 1'b1);
    check("bp_drop", v0, 0);
    check("bp_ovr_sticky", ov0, 1);

    // Reset mid-window, applied with clken low.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 16'd7, 1'b1);
    check("mid_busy", b0, 1);
    step(1'b0, 1'b0, 1'b1, 16'd7, 1'b1);
    check("mid_reset_busy", b0, 0);
    check("mid_reset_ovr", ov0, 0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b1, 16'd1, 1'b1);
    check("mid_sum", s0, 9);
    check("mid_wc", wc0, 1);
    check("mid_ovr", ov0, 0);

    // Consume and completion in the same cycle.
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b1, 16'd3, 1'b0);
    check("sim_first_sum", s0, 27);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 16'd4, 1'b0);
    check("sim_hold_sum", s0, 27);
    step(1'b1, 1'b1, 1'b1, 16'd4, 1'b1);
    check("sim_valid", v0, 1);
    check("sim_sum", s0, 36);
    check("sim_ovr", ov0, 0);
    check("sim_wc", wc0, 2);
    step(1'b1, 1'b1, 1'b0, 16'd0, 1'b1);
    check("sim_drop", v0, 0);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic        ce, rn, iv, rdy;
      logic [15:0] p;
      ce  = ($urandom_range(0, 9) != 0);
      rn  = ($urandom_range(0, 249) != 0);
      iv  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      p   = ($urandom_range(0, 2) == 0) ? 16'(16'hFFFF - $urandom_range(0, 15)) : 16'($urandom);
      step(ce, rn, iv, p, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_accumulator.md
Name: conv_accumulator

Overview:
- Stage directly downstream of the 8x8 pipelined multiplier (Mul) in the convolution engine.
- Consumes the stream of 16-bit products and sums exactly TAPS consecutive products into one convolution output per kernel window.
- Presents each result on a valid/ready output port to the write-back stage.
- Tracks completed windows and flags results lost to back-pressure.

Parameters:
- PROD_WIDTH, 16, product input width; matches multiplier result width.
- ACC_WIDTH, 24, accumulator and result width; must be >= PROD_WIDTH.
- TAPS, 9, products per window (3x3 kernel); must be >= 1.
- CNT_WIDTH, 16, width of the completed-window counter.

Ports:
- clock  input  1  rising-edge clock shared with the multiplier.
- sclr_n  input  1  synchronous active-low reset.
- clken  input  1  global clock enable; when low, all state holds.
- in_valid  input  1  product valid; aligned with the multiplier output latency.
- in_product  input  PROD_WIDTH  unsigned product from the multiplier.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_WIDTH  completed window sum.
- win_count  output  CNT_WIDTH  number of completed windows, modulo 2^CNT_WIDTH.
- overrun  output  1  sticky flag: a result was overwritten before it was consumed.
- busy  output  1  high while a window is partially accumulated (FSM in ACC_RUN).

Behaviour:
- Reset (sclr_n low at a clock edge, regardless of clken):
  - acc = 0, tap counter = 0, FSM = ACC_IDLE.
  - out_valid = 0, out_sum = 0, win_count = 0, overrun = 0, busy = 0.
  - Any partial window is discarded.
- clken low: no register changes; in_valid and out_ready are ignored; out_valid and out_sum hold.
- Accept rule: a product is accepted when clken && in_valid. There is no input back-pressure because the multiplier cannot stall.
- Arithmetic: in_product is zero-extended to ACC_WIDTH. The sum wraps modulo 2^ACC_WIDTH unless ACC_SAT_EN is defined.
- FSM:
  - ACC_IDLE: on accept, acc <= in_product and cnt <= 1, go to ACC_RUN. If TAPS==1, complete immediately and stay in ACC_IDLE.
  - ACC_RUN: on accept, if cnt == TAPS-1, complete the window: cnt <= 0, go to ACC_IDLE. Otherwise acc <= acc + in_product and cnt <= cnt+1.
  - Cycles without an accepted product do not advance the FSM; gaps inside a window are allowed.
- Completion, registered:
  - out_sum <= acc + in_product (or in_product when TAPS==1).
  - out_valid <= 1.
  - win_count <= win_count + 1, wrapping.
  - Latency: out_valid rises on the edge after the TAPS-th accepted product is sampled.
- Output handshake:
  - out_valid stays high until a cycle with clken && out_ready, after which it drops.
  - out_sum is stable while out_valid is high and no new completion occurs.
- Simultaneous consume and completion: the new result loads and out_valid stays 1. overrun is not set.
- Completion while out_valid && !out_ready: the new result overwrites out_sum (latest wins), out_valid stays 1, and overrun <= 1. overrun is cleared only by reset.
- busy = (FSM == ACC_RUN).

Optional Feature:
- Macro: ACC_SAT_EN.
- Defined: each addition saturates at 2^ACC_WIDTH-1. Once saturated, the sum stays at max for the rest of the window. The next window starts fresh.
- Undefined: plain modulo-2^ACC_WIDTH wrap; no saturation logic is synthesised.

Test Plan:
- Basic window: TAPS=9, reset, clken=1, out_ready=1, nine back-to-back products of 50 -> out_valid pulses 1 cycle after the 9th product, out_sum=450, win_count=1.
- Gaps and clken: same nine products with in_valid low on alternate cycles, plus clken low for 3 cycles mid-window -> out_sum=450. Nothing changes while clken=0. busy is high from the 1st to the 9th product.
- Wrap vs saturate: ACC_WIDTH=16, nine products of 65535 -> out_sum=65527 without ACC_SAT_EN, out_sum=65535 with ACC_SAT_EN.
- Back-pressure: out_ready=0, two windows of nine 1s then nine 2s -> out_valid held, out_sum=18, overrun=1, win_count=2. Raise out_ready -> out_valid drops next cycle.
- Reset mid-window: four products of 7, then sclr_n low 1 cycle, then nine products of 1 -> a single result, out_sum=9, win_count=1, overrun=0.
- Simultaneous consume and complete: hold out_ready=1 and complete a second window on the cycle the first is consumed -> out_valid stays 1, out_sum updates to the second sum, overrun=0.
